// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index,
// owner hold limit and a one-cycle pulse on forced handover.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 8;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [N-1:0]    r_gnt, w_gnt_nxt;
  logic [IW-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic [N-1:0]    w_arb_req;
  logic [IW-1:0]   w_arb_base;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_win_id;
  logic            w_win_found;
  logic            w_hold_last;
  logic            w_owner_rel;
  logic            w_release;

  // While granted, arbitration only matters at release: base is owner+1 and
  // the owner is masked so it cannot immediately win again.
  always_comb begin
    w_arb_base  = (r_state == S_GRANT) ? IW'(r_gnt_id + IW'(1)) : r_ptr;
    w_arb_req   = (r_state == S_GRANT) ? (req & ~r_gnt) : req;
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'(w_arb_base + IW'(k));
      if (!w_win_found && w_arb_req[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end

  always_comb begin
    w_hold_last = (r_hold_cnt == CW'(MAX_HOLD - 1));
    w_owner_rel = done | ~req[r_gnt_id];
    w_release   = w_owner_rel | w_hold_last;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = N'(1) << w_win_id;
          w_gnt_id_nxt = w_win_id;
          w_valid_nxt  = 1'b1;
          w_hold_nxt   = '0;
        end
      end
      S_GRANT: begin
        w_hold_nxt = CW'(r_hold_cnt + CW'(1));
        if (w_release) begin
          w_ptr_nxt     = IW'(r_gnt_id + IW'(1));
          w_timeout_nxt = ~w_owner_rel;
          w_hold_nxt    = '0;
          if (w_win_found) begin
            w_gnt_nxt    = N'(1) << w_win_id;
            w_gnt_id_nxt = w_win_id;
            w_valid_nxt  = 1'b1;
          end else begin
            w_state_nxt  = S_IDLE;
            w_gnt_nxt    = '0;
            w_gnt_id_nxt = '0;
            w_valid_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: vector table fed through an expectation queue,
// plus a hand-written asynchronous reset sequence.
module tb_rr_arbiter4;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter4 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  typedef struct {
    int         tag;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t m_e;

  task automatic chk(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic d,
                              input logic [3:0] g, input logic [1:0] i, input logic v, input logic t);
    vec_t x;
    x.rst_n = r; x.req = rq; x.done = d; x.gnt = g; x.id = i; x.vld = v; x.to = t;
    return x;
  endfunction

  // Monitor: pop one expectation per clock, sampled just after the edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      chk("gnt",       m_e.tag, 8'(gnt),       8'(m_e.gnt));
      chk("gnt_id",    m_e.tag, 8'(gnt_id),    8'(m_e.id));
      chk("gnt_valid", m_e.tag, 8'(gnt_valid), 8'(m_e.vld));
      chk("timeout",   m_e.tag, 8'(timeout),   8'(m_e.to));
    end
  end

  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n;
    req   = v.req;
    done  = v.done;
    e.tag = tag; e.gnt = v.gnt; e.id = v.id; e.vld = v.vld; e.to = v.to;
    sb.push_back(e);
  endtask

  initial begin
    // single requester; done on third grant cycle leaves ptr at 3
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 2, 1, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 2, 1, 0));
    vecs.push_back(mk(1, 4'b0100, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 4'b1000, 3, 1, 0));
    // rotation with done every grant
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0100, 2, 1, 0));
    vecs.push_back(mk(1, 4'b1111, 1, 4'b1000, 3, 1, 0));
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
    // forced rotation with MAX_HOLD=4
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0001, 0, 1, 1));
    vecs.push_back(mk(1, 4'b0011, 0, 4'b0001, 0, 1, 0));
    // release via request drop
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 4'b1000, 3, 1, 0));
    // done on the last hold cycle must not report a timeout
    vecs.push_back(mk(1, 4'b1000, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(mk(1, 4'b1001, 1, 4'b0001, 0, 1, 0));
    // late requests wait; non-owner drop ignored
    vecs.push_back(mk(1, 4'b1101, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0101, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0101, 1, 4'b0100, 2, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0, 0));
    // masked re-grant of a lone owner
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0001, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",   -1, 8'(gnt),       8'h00);
    chk("rst_id",    -1, 8'(gnt_id),    8'h00);
    chk("rst_valid", -1, 8'(gnt_valid), 8'h00);
    chk("rst_to",    -1, 8'(timeout),   8'h00);

    foreach (vecs[i]) apply(vecs[i], i);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drain", -2, 8'(sb.size()), 8'h00);

    // asynchronous reset while owner 2 holds the grant
    @(negedge clk);
    req = 4'b0100; done = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_gnt", 100, 8'(gnt), 8'h04);
    rst_n = 1'b0;
    #1;
    chk("async_gnt",   101, 8'(gnt),       8'h00);
    chk("async_id",    101, 8'(gnt_id),    8'h00);
    chk("async_valid", 101, 8'(gnt_valid), 8'h00);
    chk("async_to",    101, 8'(timeout),   8'h00);
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_gnt",   102, 8'(gnt),       8'h01);
    chk("post_rst_id",    102, 8'(gnt_id),    8'h00);
    chk("post_rst_valid", 102, 8'(gnt_valid), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-way round-robin arbiter that shares one downstream resource among four requesters. It registers a one-hot grant and the matching 2-bit encoded grant index, so the requester-to-index mapping sits on the same clock edge as the grant. The grant is held until the owner releases it or a hold timeout forces a handover. It sits between four request sources and the shared path they select with `gnt_id`.

## Interface
- `MAX_HOLD`, default 8: maximum cycles one owner may hold the grant before forced rotation; legal range 2..255.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request lines; `req[i]` = requester i wants the resource. Level-sensitive, held until granted and served.
- `done`  in  1  current owner finishes; sampled only while `gnt_valid`=1.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `gnt_id`  out  2  binary index of the set `gnt` bit; 0 when idle.
- `gnt_valid`  out  1  1 while any grant is active.
- `timeout`  out  1  one-cycle pulse: the previous owner was forcibly released by `MAX_HOLD`.

## Operation
- State: FSM {IDLE, GRANT}; 2-bit priority pointer `ptr`; hold counter `hold_cnt` (8 bits); registered owner index.
- Arbitration: scan `req` starting at index `ptr`, then `ptr+1`, wrapping mod 4. The first set bit wins.
- IDLE: outputs are zero. If any `req` is set, load the winner into `gnt`/`gnt_id`, set `gnt_valid`=1, clear `hold_cnt`, and go to GRANT.
- GRANT: `hold_cnt` increments each cycle. A release condition ends the grant:
  - (a) `done`=1, or
  - (b) `req[owner]`=0, or
  - (c) `hold_cnt`==`MAX_HOLD`-1 with neither (a) nor (b); this is a forced release.
- On release, `ptr` <= owner+1 mod 4. Re-arbitrate in the same cycle with `req[owner]` masked, using the new `ptr`:
  - if a winner exists, stay in GRANT with the new owner and clear `hold_cnt`;
  - otherwise go to IDLE and clear all grant outputs.
- Priority among release causes: (a)/(b) suppress (c). `timeout` is asserted only for (c).
- After reset, `ptr`=0.
- The released owner is eligible again on the next arbitration, at lowest priority.
- `gnt` is always one-hot or zero. `gnt_id` and `gnt_valid` are always consistent with `gnt`.

## Timing
- Reset (async assert, synchronous use after deassert): `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, `ptr`=0, `hold_cnt`=0, state IDLE. Reset during GRANT drops the grant immediately, without waiting for a clock edge.
- Grant latency from IDLE: `req` sampled high at edge N, so `gnt` is visible after edge N (1 cycle).
- Handover: the release condition is sampled at edge N. After edge N, the new owner's `gnt` is already valid, with no idle gap. When a new grant starts, `hold_cnt`=0.
- Hold length with no release: owner sees `gnt` for exactly `MAX_HOLD` cycles.
- `timeout` rises on the edge that performs the forced handover and is high for exactly 1 cycle. On back-to-back forced releases it pulses again each time.
- Requests asserted while a grant is active wait. They are considered only at release.
- `done` while `gnt_valid`=0 is ignored.
- A `req` bit dropping for a non-owner has no effect.

## Test plan
- **Single requester:** `req`=4'b0100 from idle, then `done` on the third grant cycle. Required: after 1 cycle `gnt`=0100, `gnt_id`=2, `gnt_valid`=1; the cycle after `done` returns to idle with `ptr`=3 and all outputs 0.
- **Rotation:** `req`=4'b1111 held, `done` pulsed once per grant. Required: grant order 0,1,2,3,0 with no idle cycle between grants, and `gnt_id` tracking 0,1,2,3,0.
- **Timeout:** `MAX_HOLD`=4, `req`=4'b0011 held, `done` never asserted. Required: owner 0 granted 4 cycles, then owner 1 granted with a 1-cycle `timeout` pulse, then owner 1 granted 4 cycles, then owner 0 with another `timeout` pulse.
- **Release via request drop:** owner 1 granted, `req` goes 4'b0010 to 4'b1000. Required: next cycle `gnt`=1000, `gnt_id`=3, `timeout`=0.
- **Reset mid-operation:** `rst_n` pulsed low while `gnt`=0100. Required: `gnt`, `gnt_id`, `gnt_valid` and `timeout` go to 0 asynchronously. After release with `req`=4'b1111, the first grant is to index 0.
- **Masked re-grant:** single owner 0 with `req`=4'b0001 asserts `done` while keeping `req[0]`=1. Required: one cycle in IDLE with outputs 0, then re-grant to 0.
